tx_req_arbiter_256: RTL

//  Round-robin arbiter between the per-channel TX ports and the single TX engine.
//  - Selects one pending channel write request.
//  - Forwards its address and length to the engine.
//  - Routes engine read-enables and sent pulses back to the granted channel.
//  - Muxes that channel's 256-bit data onto the engine data bus.
//  - One request is in flight at a time.

---
 rtl/tx_req_arbiter_256.sv | 246 ++++++++++++++++++++++++
 1 files changed

// File: rtl/tx_req_arbiter_256.sv
// ============================================================================
//  Module   : tx_req_arbiter_256
//  Purpose  : Round-robin arbiter between the per-channel TX request ports and
//             the single TX engine. Only one request is in flight at a time.
//             The winning channel's address and length are latched and handed
//             to the engine. Engine read-enables and sent pulses are routed
//             back to that channel. The channel's write data is muxed onto the
//             engine data bus.
//  Ports    :
//    CLK, RST       clock, synchronous active-high reset
//    CHNL_REQ       per-channel write request, held until its ACK
//    CHNL_REQ_ACK   per-channel request acknowledge (1-cycle pulse)
//    CHNL_ADDR      per-channel 64-bit address, channel i at [64i+63:64i]
//    CHNL_LEN       per-channel 10-bit length in 32-bit words
//    CHNL_DATA      per-channel C_DATA_WIDTH-bit write data
//    CHNL_DATA_REN  per-channel data read enable
//    CHNL_SENT      per-channel write-complete pulse
//    ENG_REQ        request to engine (registered)
//    ENG_REQ_ACK    engine accepted request
//    ENG_ADDR/LEN   latched address/length of the granted request
//    ENG_CHNL       index of the granted channel
//    ENG_DATA       data of the granted channel
//    ENG_DATA_REN   engine data read enable
//    ENG_SENT       engine finished sending the packet
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tx_req_arbiter_256 #(
  parameter int C_NUM_CHNL   = 4,    // 1..12
  parameter int C_DATA_WIDTH = 256
) (
  input  logic                                 CLK,
  input  logic                                 RST,
  input  logic [C_NUM_CHNL-1:0]                CHNL_REQ,
  output logic [C_NUM_CHNL-1:0]                CHNL_REQ_ACK,
  input  logic [64*C_NUM_CHNL-1:0]             CHNL_ADDR,
  input  logic [10*C_NUM_CHNL-1:0]             CHNL_LEN,
  input  logic [C_DATA_WIDTH*C_NUM_CHNL-1:0]   CHNL_DATA,
  output logic [C_NUM_CHNL-1:0]                CHNL_DATA_REN,
  output logic [C_NUM_CHNL-1:0]                CHNL_SENT,
  output logic                                 ENG_REQ,
  input  logic                                 ENG_REQ_ACK,
  output logic [63:0]                          ENG_ADDR,
  output logic [9:0]                           ENG_LEN,
  output logic [3:0]                           ENG_CHNL,
  output logic [C_DATA_WIDTH-1:0]              ENG_DATA,
  input  logic                                 ENG_DATA_REN,
  input  logic                                 ENG_SENT
);

  // --------------------------------------------------------------------------
  // State encoding
  // --------------------------------------------------------------------------
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_DATA = 2'd2;

  localparam logic [3:0] C_LAST_IDX = 4'(C_NUM_CHNL - 1);

  logic [1:0]            state_q;
  logic [1:0]            state_d;
  logic [3:0]            ptr_q;
  logic [3:0]            ptr_d;
  logic [3:0]            sel_q;
  logic [3:0]            sel_d;
  logic [63:0]           addr_q;
  logic [63:0]           addr_d;
  logic [9:0]            len_q;
  logic [9:0]            len_d;
  logic                  eng_req_q;

  logic                  win_vld;
  logic [3:0]            win_idx;
  logic                  grant;
  logic [C_NUM_CHNL-1:0] sel_oh;

  // --------------------------------------------------------------------------
  // Round-robin winner: scan CHNL_REQ starting at ptr_q, wrapping modulo
  // C_NUM_CHNL. The scan index never exceeds 2*C_NUM_CHNL-2, so a single
  // conditional subtract is enough to wrap it. The inner loop turns the
  // dynamic scan index into a constant bit select.
  // --------------------------------------------------------------------------
  always_comb begin
    logic [4:0] scan;
    scan    = 5'd0;
    win_vld = 1'b0;
    win_idx = 4'd0;
    for (int i = 0; i < C_NUM_CHNL; i++) begin
      scan = {1'b0, ptr_q} + 5'(i);
      if (scan >= 5'(C_NUM_CHNL)) begin
        scan = scan - 5'(C_NUM_CHNL);
      end
      for (int k = 0; k < C_NUM_CHNL; k++) begin
        if (!win_vld && (scan == 5'(k)) && CHNL_REQ[k]) begin
          win_vld = 1'b1;
          win_idx = 4'(k);
        end
      end
    end
  end

  assign grant = (state_q == S_IDLE) && win_vld;

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic. Handshakes arriving in the wrong state are ignored.
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (win_vld) begin
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (ENG_REQ_ACK) begin
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (ENG_SENT) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Grant bookkeeping: the request is latched at grant time so the engine
  // sees a stable address/length even if the channel drops or changes its
  // inputs afterwards.
  // --------------------------------------------------------------------------
  always_comb begin
    ptr_d  = ptr_q;
    sel_d  = sel_q;
    addr_d = addr_q;
    len_d  = len_q;
    if (grant) begin
      sel_d = win_idx;
      ptr_d = (win_idx == C_LAST_IDX) ? 4'd0 : (win_idx + 4'd1);
      for (int k = 0; k < C_NUM_CHNL; k++) begin
        if (win_idx == 4'(k)) begin
          addr_d = CHNL_ADDR[64*k +: 64];
          len_d  = CHNL_LEN[10*k +: 10];
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      ptr_q     <= 4'd0;
      sel_q     <= 4'd0;
      addr_q    <= 64'd0;
      len_q     <= 10'd0;
      eng_req_q <= 1'b0;
    end else begin
      ptr_q     <= ptr_d;
      sel_q     <= sel_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      // Registered request: high for exactly the cycles spent in REQ.
      eng_req_q <= (state_d == S_REQ);
    end
  end

  // --------------------------------------------------------------------------
  // FSM: outputs
  // --------------------------------------------------------------------------
  always_comb begin
    for (int k = 0; k < C_NUM_CHNL; k++) begin
      sel_oh[k] = (sel_q == 4'(k));
    end
  end

  always_comb begin
    CHNL_REQ_ACK  = '0;
    CHNL_DATA_REN = '0;
    CHNL_SENT     = '0;
    case (state_q)
      S_REQ: begin
        if (ENG_REQ_ACK) begin
          CHNL_REQ_ACK = sel_oh;
        end
        if (ENG_DATA_REN) begin
          CHNL_DATA_REN = sel_oh;
        end
      end
      S_DATA: begin
        if (ENG_DATA_REN) begin
          CHNL_DATA_REN = sel_oh;
        end
        if (ENG_SENT) begin
          CHNL_SENT = sel_oh;
        end
      end
      default: begin
        CHNL_REQ_ACK  = '0;
        CHNL_DATA_REN = '0;
        CHNL_SENT     = '0;
      end
    endcase
  end

  // Data mux follows sel_q in every state; the engine qualifies it with REN.
  always_comb begin
    ENG_DATA = '0;
    for (int k = 0; k < C_NUM_CHNL; k++) begin
      if (sel_q == 4'(k)) begin
        ENG_DATA = CHNL_DATA[C_DATA_WIDTH*k +: C_DATA_WIDTH];
      end
    end
  end

  assign ENG_REQ  = eng_req_q;
  assign ENG_ADDR = addr_q;
  assign ENG_LEN  = len_q;
  assign ENG_CHNL = sel_q;

  // --------------------------------------------------------------------------
  // Per-channel strobes must never address more than one channel.
  // --------------------------------------------------------------------------
`ifndef SYNTHESIS
  a_ack_onehot0  : assert property (@(posedge CLK) disable iff (RST) $onehot0(CHNL_REQ_ACK));
  a_ren_onehot0  : assert property (@(posedge CLK) disable iff (RST) $onehot0(CHNL_DATA_REN));
  a_sent_onehot0 : assert property (@(posedge CLK) disable iff (RST) $onehot0(CHNL_SENT));
`endif

endmodule

`default_nettype wire
